axi_mem_arbiter: RTL and testbench



---
 rtl/axi_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
// Two-master to one-slave AXI arbiter in front of the SRAM slave.
// M0 (instruction fetch) is read-only; M1 (load/store) reads and writes.
// One transaction in flight; round-robin grant; slave VALIDs held until the response handshake.
module axi_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                    CLK,
   input  logic                    RESET,
   // M0: instruction fetch, read only
   input  logic [ADDR_WIDTH-1:0]   M0_AR_ADDR,
   input  logic                    M0_AR_VALID,
   output logic                    M0_AR_READY,
   output logic [DATA_WIDTH-1:0]   M0_R_DATA,
   output logic                    M0_R_VALID,
   input  logic                    M0_R_READY,
   // M1: load/store
   input  logic [ADDR_WIDTH-1:0]   M1_AR_ADDR,
   input  logic                    M1_AR_VALID,
   output logic                    M1_AR_READY,
   output logic [DATA_WIDTH-1:0]   M1_R_DATA,
   output logic                    M1_R_VALID,
   input  logic                    M1_R_READY,
   input  logic [ADDR_WIDTH-1:0]   M1_AW_ADDR,
   input  logic                    M1_AW_VALID,
   output logic                    M1_AW_READY,
   input  logic [DATA_WIDTH-1:0]   M1_W_DATA,
   input  logic [DATA_WIDTH/8-1:0] M1_W_STRB,
   input  logic                    M1_W_VALID,
   output logic                    M1_W_READY,
   output logic                    M1_B_VALID,
   input  logic                    M1_B_READY,
   // Slave port
   output logic [ADDR_WIDTH-1:0]   S_AR_ADDR,
   output logic                    S_AR_VALID,
   input  logic                    S_AR_READY,
   input  logic [DATA_WIDTH-1:0]   S_R_DATA,
   input  logic                    S_R_VALID,
   output logic                    S_R_READY,
   output logic [ADDR_WIDTH-1:0]   S_AW_ADDR,
   output logic                    S_AW_VALID,
   input  logic                    S_AW_READY,
   output logic [DATA_WIDTH-1:0]   S_W_DATA,
   output logic [DATA_WIDTH/8-1:0] S_W_STRB,
   output logic                    S_W_VALID,
   input  logic                    S_W_READY,
   input  logic                    S_B_VALID,
   output logic                    S_B_READY
);

   localparam int unsigned StrbWidth = DATA_WIDTH / 8;

   typedef enum logic [1:0] {StIdle, StRd0, StRd1, StWr1} state_e;

   state_e                state_q, state_d;
   logic                  last_grant_q, last_grant_d;  // 1: M1 was granted last
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [StrbWidth-1:0]  strb_q, strb_d;
   logic                  ar_valid_q, ar_valid_d;
   logic                  wr_valid_q, wr_valid_d;      // drives both S_AW_VALID and S_W_VALID

   logic req0, req1w, req1;
   logic win0, win1;

   // Slave address/data readies are ignored: completion is the R or B handshake only.
   logic unused_slave_ready;
   assign unused_slave_ready = ^{S_AR_READY, S_AW_READY, S_W_READY};

   assign req0  = M0_AR_VALID;
   assign req1w = M1_AW_VALID & M1_W_VALID;
   assign req1  = req1w | M1_AR_VALID;

   // Contention goes to the master not granted last time.
   assign win0 = (state_q == StIdle) & ~RESET & req0 & (~req1 | last_grant_q);
   assign win1 = (state_q == StIdle) & ~RESET & req1 & ~win0;

   assign S_AR_VALID = ar_valid_q;
   assign S_AR_ADDR  = addr_q;
   assign S_AW_VALID = wr_valid_q;
   assign S_W_VALID  = wr_valid_q;
   assign S_AW_ADDR  = addr_q;
   assign S_W_DATA   = data_q;
   assign S_W_STRB   = strb_q;

   // Next-state, capture and combinational handshake routing.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      data_d       = data_q;
      strb_d       = strb_q;
      ar_valid_d   = ar_valid_q;
      wr_valid_d   = wr_valid_q;
      M0_AR_READY  = 1'b0;
      M1_AR_READY  = 1'b0;
      M1_AW_READY  = 1'b0;
      M1_W_READY   = 1'b0;
      M0_R_VALID   = 1'b0;
      M0_R_DATA    = '0;
      M1_R_VALID   = 1'b0;
      M1_R_DATA    = '0;
      M1_B_VALID   = 1'b0;
      S_R_READY    = 1'b0;
      S_B_READY    = 1'b0;

      // Nothing is accepted or forwarded while reset is asserted.
      if (!RESET) begin
         unique case (state_q)
            StIdle: begin
               if (win0) begin
                  M0_AR_READY  = 1'b1;
                  addr_d       = M0_AR_ADDR;
                  ar_valid_d   = 1'b1;
                  last_grant_d = 1'b0;
                  state_d      = StRd0;
               end else if (win1) begin
                  last_grant_d = 1'b1;
                  if (req1w) begin
                     // Write beats read within M1.
                     M1_AW_READY = 1'b1;
                     M1_W_READY  = 1'b1;
                     addr_d      = M1_AW_ADDR;
                     data_d      = M1_W_DATA;
                     strb_d      = M1_W_STRB;
                     wr_valid_d  = 1'b1;
                     state_d     = StWr1;
                  end else begin
                     M1_AR_READY = 1'b1;
                     addr_d      = M1_AR_ADDR;
                     ar_valid_d  = 1'b1;
                     state_d     = StRd1;
                  end
               end
            end
            StRd0: begin
               S_R_READY  = M0_R_READY;
               M0_R_VALID = S_R_VALID;
               M0_R_DATA  = S_R_DATA;
               if (S_R_VALID && M0_R_READY) begin
                  ar_valid_d = 1'b0;
                  state_d    = StIdle;
               end
            end
            StRd1: begin
               S_R_READY  = M1_R_READY;
               M1_R_VALID = S_R_VALID;
               M1_R_DATA  = S_R_DATA;
               if (S_R_VALID && M1_R_READY) begin
                  ar_valid_d = 1'b0;
                  state_d    = StIdle;
               end
            end
            StWr1: begin
               S_B_READY  = M1_B_READY;
               M1_B_VALID = S_B_VALID;
               if (S_B_VALID && M1_B_READY) begin
                  wr_valid_d = 1'b0;
                  state_d    = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and captured request registers; reset discards any in-flight transaction.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
         data_q       <= '0;
         strb_q       <= '0;
         ar_valid_q   <= 1'b0;
         wr_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         strb_q       <= strb_d;
         ar_valid_q   <= ar_valid_d;
         wr_valid_q   <= wr_valid_d;
      end
   end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Randomised bench for axi_mem_arbiter against a transaction-level reference model.
module tb_axi_mem_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int SW = DW / 8;

   logic          CLK = 1'b0;
   logic          RESET;
   logic [AW-1:0] M0_AR_ADDR, M1_AR_ADDR, M1_AW_ADDR, S_AR_ADDR, S_AW_ADDR;
   logic          M0_AR_VALID, M0_AR_READY, M0_R_VALID, M0_R_READY;
   logic          M1_AR_VALID, M1_AR_READY, M1_R_VALID, M1_R_READY;
   logic          M1_AW_VALID, M1_AW_READY, M1_W_VALID, M1_W_READY, M1_B_VALID, M1_B_READY;
   logic [DW-1:0] M0_R_DATA, M1_R_DATA, M1_W_DATA, S_R_DATA, S_W_DATA;
   logic [SW-1:0] M1_W_STRB, S_W_STRB;
   logic          S_AR_VALID, S_AR_READY, S_R_VALID, S_R_READY;
   logic          S_AW_VALID, S_AW_READY, S_W_VALID, S_W_READY, S_B_VALID, S_B_READY;

   always #5 CLK = ~CLK;

   axi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .CLK(CLK), .RESET(RESET),
      .M0_AR_ADDR(M0_AR_ADDR), .M0_AR_VALID(M0_AR_VALID), .M0_AR_READY(M0_AR_READY),
      .M0_R_DATA(M0_R_DATA), .M0_R_VALID(M0_R_VALID), .M0_R_READY(M0_R_READY),
      .M1_AR_ADDR(M1_AR_ADDR), .M1_AR_VALID(M1_AR_VALID), .M1_AR_READY(M1_AR_READY),
      .M1_R_DATA(M1_R_DATA), .M1_R_VALID(M1_R_VALID), .M1_R_READY(M1_R_READY),
      .M1_AW_ADDR(M1_AW_ADDR), .M1_AW_VALID(M1_AW_VALID), .M1_AW_READY(M1_AW_READY),
      .M1_W_DATA(M1_W_DATA), .M1_W_STRB(M1_W_STRB), .M1_W_VALID(M1_W_VALID),
      .M1_W_READY(M1_W_READY), .M1_B_VALID(M1_B_VALID), .M1_B_READY(M1_B_READY),
      .S_AR_ADDR(S_AR_ADDR), .S_AR_VALID(S_AR_VALID), .S_AR_READY(S_AR_READY),
      .S_R_DATA(S_R_DATA), .S_R_VALID(S_R_VALID), .S_R_READY(S_R_READY),
      .S_AW_ADDR(S_AW_ADDR), .S_AW_VALID(S_AW_VALID), .S_AW_READY(S_AW_READY),
      .S_W_DATA(S_W_DATA), .S_W_STRB(S_W_STRB), .S_W_VALID(S_W_VALID),
      .S_W_READY(S_W_READY), .S_B_VALID(S_B_VALID), .S_B_READY(S_B_READY)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the transaction currently owned by the slave port, if any.
   bit            tx_active, tx_owner, tx_write, last_m1;
   logic [AW-1:0] tx_addr;
   logic [DW-1:0] tx_data;
   logic [SW-1:0] tx_strb;

   // Master-side pending requests (held until accepted).
   bit m0_req, m1_aw, m1_w, m1_ar;

   // Stimulus knobs (percent).
   int p_m0, p_m1w, p_m1r, p_rdy, p_sv, p_rst;
   bit directed, force_rst;

   function automatic bit chance(input int pct);
      return $urandom_range(99, 0) < pct;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   task automatic drive();
      if (!m0_req && chance(p_m0))  m0_req = 1'b1;
      if (!m1_aw  && chance(p_m1w)) m1_aw  = 1'b1;
      if (!m1_w   && chance(p_m1w)) m1_w   = 1'b1;
      if (!m1_ar  && chance(p_m1r)) m1_ar  = 1'b1;
      M0_AR_VALID = m0_req;
      M1_AW_VALID = m1_aw;
      M1_W_VALID  = m1_w;
      M1_AR_VALID = m1_ar;
      // Fields wander every cycle; only the grant-cycle value may be captured.
      M0_AR_ADDR  = directed ? 64'h8000_0000 : rnd64();
      M1_AR_ADDR  = rnd64();
      M1_AW_ADDR  = directed ? 64'h8000_1000 : rnd64();
      M1_W_DATA   = directed ? 64'h1122_3344_5566_7788 : rnd64();
      M1_W_STRB   = directed ? 8'h0F : SW'($urandom());
      M0_R_READY  = chance(p_rdy);
      M1_R_READY  = chance(p_rdy);
      M1_B_READY  = chance(p_rdy);
      S_R_VALID   = chance(p_sv);
      S_R_DATA    = directed ? 64'h13 : rnd64();
      S_B_VALID   = chance(p_sv);
      S_AR_READY  = chance(50);
      S_AW_READY  = chance(50);
      S_W_READY   = chance(50);
      RESET       = force_rst || chance(p_rst);
      force_rst   = 1'b0;
   endtask

   task automatic evaluate();
      bit   req0, req1w, req1, win0, win1, done;
      logic e_m0_arr, e_m1_arr, e_m1_awr, e_s_arv, e_s_wrv, e_s_rr, e_s_br;
      logic e_m0_rv, e_m1_rv, e_m1_bv;
      logic [DW-1:0] e_m0_rd, e_m1_rd;
      if (RESET) begin
         check_eq("rst_m0_ar_ready", M0_AR_READY, 0);
         check_eq("rst_m1_ar_ready", M1_AR_READY, 0);
         check_eq("rst_m1_aw_ready", M1_AW_READY, 0);
         check_eq("rst_m1_w_ready", M1_W_READY, 0);
         check_eq("rst_s_r_ready", S_R_READY, 0);
         check_eq("rst_s_b_ready", S_B_READY, 0);
         check_eq("rst_r_b_valid", {M0_R_VALID, M1_R_VALID, M1_B_VALID}, 0);
         tx_active = 1'b0;
         last_m1   = 1'b1;
         return;
      end
      {win0, win1, done} = '0;
      {e_m0_arr, e_m1_arr, e_m1_awr, e_s_arv, e_s_wrv, e_s_rr, e_s_br} = '0;
      {e_m0_rv, e_m1_rv, e_m1_bv} = '0;
      e_m0_rd = '0;
      e_m1_rd = '0;
      req0  = M0_AR_VALID;
      req1w = M1_AW_VALID && M1_W_VALID;
      req1  = req1w || M1_AR_VALID;
      if (!tx_active) begin
         win0     = req0 && (!req1 || last_m1);
         win1     = req1 && !win0;
         e_m0_arr = win0;
         e_m1_awr = win1 && req1w;
         e_m1_arr = win1 && !req1w;
      end else if (tx_write) begin
         e_s_wrv = 1'b1;
         e_s_br  = M1_B_READY;
         e_m1_bv = S_B_VALID;
         done    = S_B_VALID && M1_B_READY;
      end else begin
         e_s_arv = 1'b1;
         e_s_rr  = tx_owner ? M1_R_READY : M0_R_READY;
         if (tx_owner) begin
            e_m1_rv = S_R_VALID;
            e_m1_rd = S_R_DATA;
         end else begin
            e_m0_rv = S_R_VALID;
            e_m0_rd = S_R_DATA;
         end
         done = S_R_VALID && e_s_rr;
      end
      check_eq("m0_ar_ready", M0_AR_READY, e_m0_arr);
      check_eq("m1_ar_ready", M1_AR_READY, e_m1_arr);
      check_eq("m1_aw_ready", M1_AW_READY, e_m1_awr);
      check_eq("m1_w_ready", M1_W_READY, e_m1_awr);
      check_eq("s_ar_valid", S_AR_VALID, e_s_arv);
      check_eq("s_aw_valid", S_AW_VALID, e_s_wrv);
      check_eq("s_w_valid", S_W_VALID, e_s_wrv);
      check_eq("s_r_ready", S_R_READY, e_s_rr);
      check_eq("s_b_ready", S_B_READY, e_s_br);
      check_eq("m0_r_valid", M0_R_VALID, e_m0_rv);
      check_eq("m1_r_valid", M1_R_VALID, e_m1_rv);
      check_eq("m1_b_valid", M1_B_VALID, e_m1_bv);
      check_eq("m0_r_data", M0_R_DATA, e_m0_rd);
      check_eq("m1_r_data", M1_R_DATA, e_m1_rd);
      if (tx_active && !tx_write) check_eq("s_ar_addr", S_AR_ADDR, tx_addr);
      if (tx_active && tx_write) begin
         check_eq("s_aw_addr", S_AW_ADDR, tx_addr);
         check_eq("s_w_data", S_W_DATA, tx_data);
         check_eq("s_w_strb", S_W_STRB, 64'(tx_strb));
      end
      // Advance the model to the state after the coming clock edge.
      if (win0) begin
         tx_active = 1'b1;
         tx_owner  = 1'b0;
         tx_write  = 1'b0;
         tx_addr   = M0_AR_ADDR;
         last_m1   = 1'b0;
         m0_req    = 1'b0;
      end else if (win1) begin
         tx_active = 1'b1;
         tx_owner  = 1'b1;
         last_m1   = 1'b1;
         if (req1w) begin
            tx_write = 1'b1;
            tx_addr  = M1_AW_ADDR;
            tx_data  = M1_W_DATA;
            tx_strb  = M1_W_STRB;
            m1_aw    = 1'b0;
            m1_w     = 1'b0;
         end else begin
            tx_write = 1'b0;
            tx_addr  = M1_AR_ADDR;
            m1_ar    = 1'b0;
         end
      end
      if (done) tx_active = 1'b0;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      drive();
      @(negedge CLK);
      evaluate();
   endtask

   task automatic knobs(input int m0, input int m1w, input int m1r, input int rdy, input int sv,
                        input int rst);
      p_m0  = m0;
      p_m1w = m1w;
      p_m1r = m1r;
      p_rdy = rdy;
      p_sv  = sv;
      p_rst = rst;
   endtask

   initial begin
      bit wr_hit;
      {m0_req, m1_aw, m1_w, m1_ar, directed, force_rst} = '0;
      RESET = 1'b1;
      {M0_AR_VALID, M1_AR_VALID, M1_AW_VALID, M1_W_VALID} = '0;
      {M0_R_READY, M1_R_READY, M1_B_READY, S_R_VALID, S_B_VALID} = '0;
      {S_AR_READY, S_AW_READY, S_W_READY} = '0;
      M0_AR_ADDR = '0; M1_AR_ADDR = '0; M1_AW_ADDR = '0;
      M1_W_DATA  = '0; M1_W_STRB  = '0; S_R_DATA   = '0;
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;
      @(negedge CLK);
      check_eq("reset_valids", {S_AR_VALID, S_AW_VALID, S_W_VALID}, 0);
      check_eq("reset_readies", {M0_AR_READY, M1_AR_READY, M1_AW_READY, M1_W_READY}, 0);
      check_eq("reset_s_readies", {S_R_READY, S_B_READY}, 0);
      check_eq("reset_resp", {M0_R_VALID, M1_R_VALID, M1_B_VALID}, 0);
      check_eq("reset_ar_addr", S_AR_ADDR, 0);
      check_eq("reset_aw_addr", S_AW_ADDR, 0);
      check_eq("reset_w_data", S_W_DATA, 0);
      check_eq("reset_w_strb", 64'(S_W_STRB), 0);
      tx_active = 1'b0;
      last_m1   = 1'b1;

      // Directed single M0 read, then single M1 write.
      directed = 1'b1;
      knobs(100, 0, 0, 60, 50, 0);
      repeat (12) step();
      knobs(0, 100, 0, 60, 50, 0);
      repeat (12) step();
      directed = 1'b0;

      // General random traffic with occasional resets.
      knobs(40, 30, 30, 70, 60, 1);
      repeat (1500) step();

      // Permanent contention between M0 and M1 reads.
      knobs(100, 0, 100, 100, 100, 0);
      repeat (100) step();

      // Heavy response stalls, writes and reads competing.
      knobs(40, 50, 50, 15, 50, 2);
      repeat (800) step();

      // Reset while a write is outstanding, then fresh M0 reads.
      knobs(0, 100, 0, 0, 50, 0);
      wr_hit = 1'b0;
      for (int i = 0; i < 200 && !wr_hit; i++) begin
         step();
         if (tx_active && tx_write) wr_hit = 1'b1;
      end
      check_eq("wr1_reached", 64'(wr_hit), 1);
      knobs(100, 0, 0, 80, 60, 0);
      m1_aw = 1'b0;
      m1_w  = 1'b0;
      force_rst = 1'b1;
      repeat (40) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
